// File: rtl/accumulator_bus_controller.sv
// accumulator_bus_controller
//   Responder end of the accumulator bus. Arbitrates req from NPROC
//   processors, grants the bus to one at a time, serves FETCH from a host-fed
//   operand FIFO and deposits SEND data into a host-drained result FIFO.
//   Every completed transfer ends with a one-cycle signal pulse.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   req   [NPROC-1:0]      : per-processor bus request
//   grant [NPROC-1:0]      : one-hot grant (registered)
//   op    [1:0]            : 01 FETCH, 10 SEND, anything else NOP
//   read  [31:0]           : operand to processor (registered)
//   write [31:0]           : result from granted processor
//   signal                 : transfer-complete pulse (registered)
//   opnd_valid/data/ready  : host push into operand FIFO
//   res_valid/data/ready   : host pop from result FIFO (data = head, comb)
//   busy                   : state is not IDLE
//
// Build option
//   ARB_RR_EN : round-robin arbitration; otherwise fixed priority (index 0
//               highest) with no pointer register.

module accumulator_bus_controller #(
  parameter int NPROC      = 4,
  parameter int DEPTH      = 16,
  parameter int OP_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NPROC-1:0] req,
  output logic [NPROC-1:0] grant,
  input  logic [1:0]       op,
  output logic [31:0]      read,
  input  logic [31:0]      write,
  output logic             signal,
  input  logic             opnd_valid,
  input  logic [31:0]      opnd_data,
  output logic             opnd_ready,
  output logic             res_valid,
  output logic [31:0]      res_data,
  input  logic             res_ready,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(OP_TIMEOUT + 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST  = TW'(OP_TIMEOUT - 1);
  localparam logic [1:0]    OP_FETCH  = 2'b01;
  localparam logic [1:0]    OP_SEND   = 2'b10;

  typedef enum logic [1:0] {IDLE, GRANT_WAIT, SERVE} state_t;

  state_t          state;
  logic [TW-1:0]   tmo_cnt;
  logic            pending_fetch, pending_send;

  // operand FIFO
  logic [31:0]     opnd_mem [DEPTH];
  logic [AW-1:0]   opnd_wr, opnd_rd;
  logic [AW:0]     opnd_cnt;
  logic            opnd_push, opnd_pop;

  // result FIFO
  logic [31:0]     res_mem [DEPTH];
  logic [AW-1:0]   res_wr, res_rd;
  logic [AW:0]     res_cnt;
  logic            res_push, res_pop;

  logic            do_fetch, do_send;
  logic [NPROC-1:0] win;

  assign opnd_ready = (opnd_cnt != FIFO_FULL);
  assign res_valid  = (res_cnt != '0);
  assign res_data   = res_mem[res_rd];
  assign busy       = (state != IDLE);
  assign opnd_push  = opnd_valid && opnd_ready;
  assign res_pop    = res_valid && res_ready;

  // A latched pending op takes precedence over whatever op shows now, since
  // the processor may already have returned op to NOP while stalled.
  always_comb begin
    do_fetch = 1'b0;
    do_send  = 1'b0;
    if (state == GRANT_WAIT) begin
      if (pending_fetch || (!pending_send && op == OP_FETCH))
        do_fetch = 1'b1;
      else if (pending_send || op == OP_SEND)
        do_send = 1'b1;
    end
    opnd_pop = do_fetch && (opnd_cnt != '0);
    // a host pop in the same cycle frees the slot we are about to fill
    res_push = do_send && ((res_cnt != FIFO_FULL) || res_pop);
  end

`ifdef ARB_RR_EN
  localparam int PW = (NPROC > 1) ? $clog2(NPROC) : 1;
  // rr_ptr holds the index where the next search starts (last winner + 1),
  // so it resets to 0 and index 0 wins first.
  logic [PW-1:0] rr_ptr, win_idx;

  always_comb begin
    int   idx;
    logic found;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NPROC; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NPROC) idx = idx - NPROC;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        win_idx  = PW'(idx);
        found    = 1'b1;
      end
    end
  end
`else
  always_comb begin
    logic found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NPROC; i++) begin
      if (!found && req[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif

  // storage arrays carry no reset; pointers/counts below define validity
  always_ff @(posedge clk) begin
    if (opnd_push) opnd_mem[opnd_wr] <= opnd_data;
    if (res_push)  res_mem[res_wr]   <= write;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      read          <= '0;
      signal        <= 1'b0;
      tmo_cnt       <= '0;
      pending_fetch <= 1'b0;
      pending_send  <= 1'b0;
      opnd_wr       <= '0;
      opnd_rd       <= '0;
      opnd_cnt      <= '0;
      res_wr        <= '0;
      res_rd        <= '0;
      res_cnt       <= '0;
`ifdef ARB_RR_EN
      rr_ptr        <= '0;
`endif
    end else begin
      if (opnd_push) opnd_wr <= opnd_wr + 1'b1;
      if (opnd_pop)  opnd_rd <= opnd_rd + 1'b1;
      case ({opnd_push, opnd_pop})
        2'b10:   opnd_cnt <= opnd_cnt + 1'b1;
        2'b01:   opnd_cnt <= opnd_cnt - 1'b1;
        default: opnd_cnt <= opnd_cnt;
      endcase

      if (res_push) res_wr <= res_wr + 1'b1;
      if (res_pop)  res_rd <= res_rd + 1'b1;
      case ({res_push, res_pop})
        2'b10:   res_cnt <= res_cnt + 1'b1;
        2'b01:   res_cnt <= res_cnt - 1'b1;
        default: res_cnt <= res_cnt;
      endcase

      case (state)
        IDLE: begin
          signal <= 1'b0;
          if (|req) begin
            grant   <= win;
            tmo_cnt <= '0;
            state   <= GRANT_WAIT;
`ifdef ARB_RR_EN
            rr_ptr  <= (win_idx == PW'(NPROC - 1)) ? '0 : win_idx + 1'b1;
`endif
          end
        end
        GRANT_WAIT: begin
          if (opnd_pop) begin
            read          <= opnd_mem[opnd_rd];
            signal        <= 1'b1;
            pending_fetch <= 1'b0;
            state         <= SERVE;
          end else if (do_fetch) begin
            pending_fetch <= 1'b1;
          end else if (res_push) begin
            signal        <= 1'b1;
            pending_send  <= 1'b0;
            state         <= SERVE;
          end else if (do_send) begin
            pending_send  <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            // nobody spoke up: revoke silently
            grant <= '0;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SERVE: begin
          // the forced IDLE cycle lets the served processor drop its req
          signal <= 1'b0;
          grant  <= '0;
          read   <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
